// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate read cache between the
// MEM stage and the SRAM controller. Hits return data combinationally; misses and writes stall.
module cache_controller #(
  parameter int          SETS      = 64,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_res,
  input  logic [31:0] st_value,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
  output logic [1:0]  dbg_state
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 16 - IW;

  // Handshake: the pipeline holds mem_r_en/mem_w_en/alu_res/st_value stable while
  // ready=0; an access completes in the cycle ready=1. Toward SRAM, sram_r_en or
  // sram_w_en is held until the cycle sram_ready=1 and drops in the following cycle.
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state, state_nx;

  logic [31:0]   a;
  logic          word_sel;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          unused_addr_bits;

  assign a                = alu_res - BASE_ADDR;
  assign word_sel         = a[2];
  assign idx              = a[3+IW-1:3];
  assign tag              = a[18:3+IW];
  assign unused_addr_bits = ^{a[31:19], a[1:0]};

  logic [SETS-1:0] valid0, valid1, lru;
  logic [TW-1:0]   tag0  [SETS];
  logic [TW-1:0]   tag1  [SETS];
  logic [63:0]     data0 [SETS];
  logic [63:0]     data1 [SETS];

  logic        hit0, hit1, hit, hit_way, victim, is_rd, is_wr;
  logic [63:0] hit_line;
  logic [31:0] hit_word, rd_word;
  logic        fill, wr_word, touch, touch_way;

  assign hit0     = valid0[idx] && (tag0[idx] == tag);
  assign hit1     = valid1[idx] && (tag1[idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_line = hit0 ? data0[idx] : data1[idx];
  assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];
  // Empty ways are filled before anything is evicted, way0 first.
  assign victim   = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);
  // A simultaneous load and store request is handled as a store.
  assign is_wr    = mem_w_en;
  assign is_rd    = mem_r_en & ~mem_w_en;

  assign sram_addr  = alu_res;
  assign sram_wdata = st_value;
  assign dbg_state  = state;
  assign rdata      = (ready && is_rd) ? rd_word : 32'd0;

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    rd_word   = 32'd0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    fill      = 1'b0;
    wr_word   = 1'b0;
    touch     = 1'b0;
    touch_way = 1'b0;
    case (state)
      IDLE: begin
        if (is_wr) begin
          state_nx = WR_THRU;
        end else if (is_rd) begin
          if (hit) begin
            ready     = 1'b1;
            rd_word   = hit_word;
            touch     = 1'b1;
            touch_way = hit_way;
          end else begin
            state_nx = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        sram_r_en = 1'b1;
        if (sram_ready) begin
          ready     = 1'b1;
          rd_word   = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
          fill      = 1'b1;
          touch     = 1'b1;
          touch_way = victim;
          state_nx  = IDLE;
        end
      end
      WR_THRU: begin
        sram_w_en = 1'b1;
        if (sram_ready) begin
          ready    = 1'b1;
          state_nx = IDLE;
          if (hit) begin
            wr_word   = 1'b1;
            touch     = 1'b1;
            touch_way = hit_way;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      state <= state_nx;
      if (fill) begin
        if (victim) valid1[idx] <= 1'b1;
        else        valid0[idx] <= 1'b1;
      end
      if (touch) lru[idx] <= ~touch_way;
    end
  end

  // Tag and data storage carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill) begin
      if (victim) begin
        tag1[idx]  <= tag;
        data1[idx] <= sram_rdata;
      end else begin
        tag0[idx]  <= tag;
        data0[idx] <= sram_rdata;
      end
    end
    if (wr_word) begin
      if (hit_way) begin
        if (word_sel) data1[idx][63:32] <= st_value;
        else          data1[idx][31:0]  <= st_value;
      end else begin
        if (word_sel) data0[idx][63:32] <= st_value;
        else          data0[idx][31:0]  <= st_value;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed table of spec scenarios, a reset-during-miss
// sequence, then random loads/stores against a recency-list cache model and a word memory.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, st_value;
  logic        ready;
  logic [31:0] rdata;
  logic        sram_r_en, sram_w_en;
  logic [31:0] sram_addr, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  cache_controller dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .st_value(st_value), .ready(ready), .rdata(rdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: backing memory of words plus, per set, the cached line tags in
  // recency order (front = least recently used, at most two).
  logic [31:0] mem [int];
  int          set_q [64][$];

  function automatic int set_of(input logic [31:0] addr);
    logic [31:0] a = addr - 32'd1024;
    return int'((a >> 3) & 32'h3F);
  endfunction

  function automatic int tag_of(input logic [31:0] addr);
    logic [31:0] a = addr - 32'd1024;
    return int'((a >> 9) & 32'h3FF);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    int key = int'(addr & ~32'd3);
    if (mem.exists(key)) return mem[key];
    return (addr & ~32'd3) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] mem_line(input logic [31:0] addr);
    logic [31:0] base = addr & ~32'd7;
    return {mem_word(base + 32'd4), mem_word(base)};
  endfunction

  function automatic bit model_hit(input logic [31:0] addr);
    int s = set_of(addr);
    foreach (set_q[s][i]) if (set_q[s][i] == tag_of(addr)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data);
    int s = set_of(addr);
    int t = tag_of(addr);
    int pos = -1;
    foreach (set_q[s][i]) if (set_q[s][i] == t) pos = i;
    if (wr) mem[int'(addr & ~32'd3)] = data;
    if (pos >= 0) begin
      set_q[s].delete(pos);
      set_q[s].push_back(t);
    end else if (rd && !wr) begin
      if (set_q[s].size() == 2) void'(set_q[s].pop_front());
      set_q[s].push_back(t);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++) set_q[s].delete();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One pipeline access, with the SRAM answering on wait cycle dly (dly >= 1).
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int dly, input bit exp_hit,
                        input logic [31:0] exp_rdata, input string nm);
    @(negedge clk);
    mem_r_en = rd; mem_w_en = wr; alu_res = addr; st_value = data; sram_ready = 1'b0;
    #1;
    chk({nm, ".sram_addr"}, 64'(sram_addr), 64'(addr));
    if (!wr && exp_hit) begin
      chk({nm, ".hit_ready"}, 64'(ready), 64'd1);
      chk({nm, ".hit_rdata"}, 64'(rdata), 64'(exp_rdata));
      chk({nm, ".hit_sram_r_en"}, 64'(sram_r_en), 64'd0);
    end else begin
      chk({nm, ".req_ready"}, 64'(ready), 64'd0);
      for (int c = 1; c <= dly; c++) begin
        @(negedge clk);
        sram_rdata = {$urandom, $urandom};
        if (c == dly) begin
          sram_ready = 1'b1;
          sram_rdata = mem_line(addr);
        end
        #1;
        chk({nm, ".wait_r_en"}, 64'(sram_r_en), 64'(!wr));
        chk({nm, ".wait_w_en"}, 64'(sram_w_en), 64'(wr));
        chk({nm, ".wait_ready"}, 64'(ready), 64'(c == dly));
        if (wr) chk({nm, ".sram_wdata"}, 64'(sram_wdata), 64'(data));
        if (c == dly && !wr) chk({nm, ".miss_rdata"}, 64'(rdata), 64'(exp_rdata));
      end
    end
    @(negedge clk);
    mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0;
    #1;
    chk({nm, ".drop_r_en"}, 64'(sram_r_en), 64'd0);
    chk({nm, ".drop_w_en"}, 64'(sram_w_en), 64'd0);
    chk({nm, ".idle_ready"}, 64'(ready), 64'd1);
    chk({nm, ".idle_rdata"}, 64'(rdata), 64'd0);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          dly;
    bit          hit;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{1, 0, 32'h400,  32'h0,         3,  0, 32'h3333_4444});
    tbl.push_back('{1, 0, 32'h404,  32'h0,         1,  1, 32'h1111_2222});
    tbl.push_back('{0, 1, 32'h404,  32'hDEAD_BEEF, 2,  0, 32'h0});
    tbl.push_back('{1, 0, 32'h404,  32'h0,         1,  1, 32'hDEAD_BEEF});
    tbl.push_back('{0, 1, 32'h1000, 32'h1234_5678, 1,  0, 32'h0});
    tbl.push_back('{1, 0, 32'h1000, 32'h0,         2,  0, 32'h1234_5678});
    tbl.push_back('{1, 0, 32'h400,  32'h0,         1,  1, 32'h3333_4444});
    tbl.push_back('{1, 0, 32'h600,  32'h0,         2,  0, 32'h6666_0000});
    tbl.push_back('{1, 0, 32'h800,  32'h0,         1,  0, 32'h8888_0000});
    tbl.push_back('{1, 0, 32'h600,  32'h0,         1,  1, 32'h6666_0000});
    tbl.push_back('{1, 0, 32'h400,  32'h0,         1,  0, 32'h3333_4444});
    tbl.push_back('{0, 1, 32'h604,  32'hCAFE_F00D, 11, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h604,  32'h0,         1,  1, 32'hCAFE_F00D});
    tbl.push_back('{1, 1, 32'h408,  32'h0BAD_F00D, 1,  0, 32'h0});
    tbl.push_back('{1, 0, 32'h408,  32'h0,         2,  0, 32'h0BAD_F00D});

    mem[32'h400] = 32'h3333_4444;
    mem[32'h404] = 32'h1111_2222;
    mem[32'h600] = 32'h6666_0000;
    mem[32'h800] = 32'h8888_0000;

    // Clock/reset
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = '0; st_value = '0;
    sram_rdata = '0; sram_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.ready_idle", 64'(ready), 64'd1);
    chk("rst.rdata", 64'(rdata), 64'd0);
    chk("rst.sram_r_en", 64'(sram_r_en), 64'd0);
    chk("rst.sram_w_en", 64'(sram_w_en), 64'd0);
    mem_r_en = 1'b1;
    #1;
    chk("rst.ready_req", 64'(ready), 64'd0);
    mem_r_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Directed table
    foreach (tbl[i]) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].dly,
             tbl[i].hit, tbl[i].rdata, $sformatf("tbl%0d", i));
      model_update(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
    end

    // Reset asserted while a read miss waits on SRAM
    @(negedge clk);
    mem_r_en = 1'b1; alu_res = 32'h2000;
    #1;
    chk("rstmiss.req_ready", 64'(ready), 64'd0);
    @(negedge clk); #1;
    chk("rstmiss.r_en_wait", 64'(sram_r_en), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmiss.r_en_drop", 64'(sram_r_en), 64'd0);
    chk("rstmiss.ready_req", 64'(ready), 64'd0);
    mem_r_en = 1'b0;
    #1;
    chk("rstmiss.ready_idle", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    access(1, 0, 32'h400, 32'h0, 2, 0, 32'h3333_4444, "rstmiss.reread");
    model_update(1, 0, 32'h400, 32'h0);

    // Random loads/stores over a few sets and tags so hits and evictions recur
    for (int i = 0; i < 250; i++) begin
      int          op  = $urandom_range(0, 9);
      bit          rd  = (op >= 3) || (op == 0);
      bit          wr  = (op <= 2);
      logic [31:0] adr = 32'h400 + ((32'($urandom_range(0, 3)) << 9) |
                                    (32'($urandom_range(0, 3)) << 3) |
                                    (32'($urandom_range(0, 1)) << 2));
      logic [31:0] dat = $urandom;
      access(rd, wr, adr, dat, $urandom_range(1, 4), model_hit(adr), mem_word(adr),
             $sformatf("rnd%0d", i));
      model_update(rd, wr, adr, dat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
